uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver. Majority-of-3 mid-bit sampling,
//            optional even/odd parity, stop-bit check, break handling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic [5:0]            prescale,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int              c_BW   = $clog2(DATA_WIDTH + 1);
    localparam logic [c_BW-1:0] c_LAST = c_BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [5:0]            r_cnt;
    logic [5:0]            r_p;
    logic [c_BW-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_type;
    logic                  r_s0;
    logic                  r_s1;
    logic                  r_need_high;

    logic [5:0]            w_p_sel;
    logic [5:0]            w_half;
    logic                  w_detect;
    logic                  w_smp0;
    logic                  w_smp1;
    logic                  w_dec;
    logic                  w_end;
    logic                  w_maj;

    // Unsupported oversampling ratios fall back to 8 clocks per bit.
    assign w_p_sel  = (prescale == 6'd8 || prescale == 6'd16 || prescale == 6'd32) ? prescale : 6'd8;
    assign w_half   = {1'b0, r_p[5:1]};
    assign w_smp0   = (r_cnt == w_half - 6'd1);
    assign w_smp1   = (r_cnt == w_half);
    assign w_dec    = (r_cnt == w_half + 6'd1);
    assign w_end    = (r_cnt == r_p - 6'd1);
    // A start is only accepted once the line has been seen high after a break.
    assign w_detect = (r_state == IDLE) && !rx_in && !r_need_high;
    // Third sample is the live line value on the decision count.
    assign w_maj    = (r_s0 & r_s1) | (r_s0 & rx_in) | (r_s1 & rx_in);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic; STOP leaves early so a following start is not missed.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_detect) w_next = START;
            START: begin
                if (w_dec && w_maj) w_next = IDLE;
                else if (w_end)     w_next = DATA;
            end
            DATA:    if (w_end && r_bit_cnt == c_LAST) w_next = r_par_en ? PARITY : STOP;
            PARITY:  if (w_end) w_next = STOP;
            STOP:    if (w_dec) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Edge counter; the detection cycle itself is count 0 of the start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    r_cnt <= 6'd0;
        else if (r_state == IDLE)    r_cnt <= w_detect ? 6'd1 : 6'd0;
        else if (w_next == IDLE)     r_cnt <= 6'd0;
        else if (w_end)              r_cnt <= 6'd0;
        else                         r_cnt <= r_cnt + 6'd1;
    end

    // Frame configuration captured at start detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p        <= 6'd8;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
        end else if (w_detect) begin
            r_p        <= w_p_sel;
            r_par_en   <= par_en;
            r_par_type <= par_type;
        end
    end

    // First two of the three mid-bit samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else if (r_state != IDLE) begin
            if (w_smp0) r_s0 <= rx_in;
            if (w_smp1) r_s1 <= rx_in;
        end
    end

    // Data bit counter and LSB-first shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (r_state == DATA) begin
            if (w_dec) r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
            if (w_end) r_bit_cnt <= (r_bit_cnt == c_LAST) ? '0 : r_bit_cnt + 1'b1;
        end else begin
            r_bit_cnt <= '0;
        end
    end

    // Break tracking: after a low stop bit, demand a high line before re-arming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  r_need_high <= 1'b0;
        else if (r_state == STOP && w_dec && !w_maj) r_need_high <= 1'b1;
        else if (rx_in)                            r_need_high <= 1'b0;
    end

    // Result outputs; errors clear only once a start bit is confirmed so a
    // rejected glitch leaves every output untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_data       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (r_state == START && w_dec && !w_maj) begin
                parity_error <= 1'b0;
                stop_error   <= 1'b0;
            end
            if (r_state == PARITY && w_dec)
                parity_error <= w_maj ^ (^r_shift) ^ r_par_type;
            if (r_state == STOP && w_dec) begin
                stop_error <= !w_maj;
                if (w_maj && !parity_error) begin
                    data_valid <= 1'b1;
                    p_data     <= r_shift;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx: directed frames plus random
//            frames compared against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic       par_en;
    logic       par_type;
    logic [5:0] prescale;
    logic [7:0] p_data;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int det_cyc  = 0;

    logic [7:0] got_q[$];
    int         dv_cyc_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_pdata = 8'h00;
    logic       exp_pe    = 1'b0;
    logic       exp_se    = 1'b0;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .rx_in        (rx_in),
        .par_en       (par_en),
        .par_type     (par_type),
        .prescale     (prescale),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every data_valid pulse away from the active edge.
    always @(negedge clk) begin
        if (data_valid) begin
            got_q.push_back(p_data);
            dv_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold one bit for p clocks; cycle gpos (if any) carries the inverted level.
    task automatic drive_bit(input logic v, input int p, input int gpos);
        for (int j = 0; j < p; j++) begin
            rx_in = (j == gpos) ? ~v : v;
            @(posedge clk);
            #1;
        end
    endtask

    // Send one frame and update the frame-level expectation.
    task automatic send_frame(input logic [7:0] d, input int pres, input logic pe, input logic pt,
                              input logic pbit, input logic sbit, input bit glitch,
                              input int stop_len, input bit scramble);
        int p;
        int g;
        int sl;
        p  = (pres == 8 || pres == 16 || pres == 32) ? pres : 8;
        sl = (stop_len > 0) ? stop_len : p;
        prescale = 6'(pres);
        par_en   = pe;
        par_type = pt;
        det_cyc  = cyc + 1;
        drive_bit(1'b0, p, -1);
        if (scramble) begin
            par_en   = 1'($urandom);
            par_type = 1'($urandom);
            prescale = 6'(8 << $urandom_range(2, 0));
        end
        for (int i = 0; i < 8; i++) begin
            g = glitch ? int'($urandom_range(p / 2 + 1, p / 2 - 1)) : -1;
            drive_bit(d[i], p, g);
        end
        if (pe) drive_bit(pbit, p, -1);
        for (int j = 0; j < sl; j++) begin
            rx_in = sbit;
            @(posedge clk);
            #1;
        end
        rx_in  = 1'b1;
        exp_pe = pe && (pbit != ((^d) ^ pt));
        exp_se = !sbit;
        if (!exp_pe && !exp_se) begin
            exp_q.push_back(d);
            exp_pdata = d;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":dv_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, ":dv_data"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        dv_cyc_q.delete();
        check({tag, ":p_data"}, p_data, exp_pdata);
        check({tag, ":parity_error"}, parity_error, exp_pe);
        check({tag, ":stop_error"}, stop_error, exp_se);
        check({tag, ":dv_idle"}, data_valid, 1'b0);
    endtask

    initial begin
        int lat;
        int plist[8];
        logic [7:0] d;
        logic pe;
        logic pt;
        logic pb;
        logic sb;
        plist = '{8, 16, 32, 8, 16, 32, 12, 0};

        rst_n = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_type = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:p_data", p_data, 8'h00);
        check("reset:data_valid", data_valid, 1'b0);
        check("reset:parity_error", parity_error, 1'b0);
        check("reset:stop_error", stop_error, 1'b0);
        rst_n = 1'b1;
        idle(5);

        // Basic 8N1 frame with latency measurement.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(4);
        lat = (dv_cyc_q.size() > 0) ? dv_cyc_q[0] - det_cyc : -1;
        check("a5:latency_76pm1", (lat >= 75 && lat <= 77), 1'b1);
        check_outputs("a5");

        // Even parity, good then bad parity bit.
        send_frame(8'h03, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(4);
        check_outputs("even_ok");
        send_frame(8'h03, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        idle(4);
        check_outputs("even_bad");

        // Odd parity correct, stop bit low.
        send_frame(8'hFF, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(4);
        check_outputs("stop_err");

        // Two-clock glitch must leave outputs untouched.
        prescale = 6'd8; par_en = 1'b0;
        rx_in = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        idle(20);
        check_outputs("glitch");
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(4);
        check_outputs("after_glitch");

        // Back-to-back, full stop bit, no idle gap.
        send_frame(8'h11, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        send_frame(8'hEE, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(4);
        check_outputs("b2b_32");

        // Start bit one cycle after returning to idle.
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6, 1'b0);
        send_frame(8'h69, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(4);
        check_outputs("b2b_short_stop");

        // Reset during data bit 4.
        d = 8'hC7;
        prescale = 6'd8; par_en = 1'b0;
        drive_bit(1'b0, 8, -1);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 8, -1);
        rx_in = d[4];
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rst_mid:p_data", p_data, 8'h00);
        check("rst_mid:data_valid", data_valid, 1'b0);
        check("rst_mid:parity_error", parity_error, 1'b0);
        check("rst_mid:stop_error", stop_error, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_pdata = 8'h00; exp_pe = 1'b0; exp_se = 1'b0;
        idle(100);
        check_outputs("rst_abort");
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(4);
        check_outputs("after_rst");

        // One corrupted sample per data bit.
        send_frame(8'hB4, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        idle(4);
        check_outputs("glitch_bits16");
        send_frame(8'h4B, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        idle(4);
        check_outputs("glitch_bits8");

        // Unsupported prescale behaves as 8.
        send_frame(8'hD2, 12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(4);
        check_outputs("prescale_12");

        // Break: line held low well past the frame, then one high clock.
        prescale = 6'd8; par_en = 1'b0;
        rx_in = 1'b0;
        repeat (110) begin @(posedge clk); #1; end
        exp_pe = 1'b0; exp_se = 1'b1;
        check_outputs("break");
        idle(1);
        send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(4);
        check_outputs("after_break");

        // Random frames with mid-frame configuration changes.
        for (int k = 0; k < 24; k++) begin
            d  = 8'($urandom);
            pe = 1'($urandom);
            pt = 1'($urandom);
            pb = ($urandom_range(3, 0) == 0) ? ~((^d) ^ pt) : ((^d) ^ pt);
            sb = ($urandom_range(5, 0) != 0);
            send_frame(d, plist[$urandom_range(7, 0)], pe, pt, pb, sb,
                       1'($urandom), 0, 1'b1);
            idle(int'($urandom_range(6, 2)));
            check_outputs("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
